trap_ctrl_unit: RTL and testbench
=================================

// Module: trap_ctrl_unit
// PURPOSE
//  Machine-mode trap controller; parametrised successor of the single-IRQ exception unit.
//  Owns mstatus/mie/mip/mtvec/mepc/mcause/mtval; prioritises NUM_IRQ level interrupts and 4 sync exceptions.
//  Sits beside the MEM stage: flushes the pipeline, then redirects the PC via a 2-state FSM.
// PARAMETERS
//  NUM_IRQ        8             interrupt lines, 1..16
//  IRQ_CAUSE_BASE 16            cause code of irq_in[0]; irq_in[i] -> IRQ_CAUSE_BASE+i
//  MTVEC_RESET    32'h0000_0000 mtvec reset value
// PORTS
//  clk              in   1        clock
//  rst              in   1        synchronous active-high reset
//  csr_rw_in        in   1        CSR instruction valid this cycle
//  csr_wsc_mode_in  in   2        00 none, 01 write, 10 set bits, 11 clear bits
//  csr_rw_addr_in   in   12       CSR address
//  csr_w_data       in   32       write operand (imm already zero-extended upstream)
//  csr_r_data_out   out  32       read data, combinational from csr_rw_addr_in
//  irq_in           in   NUM_IRQ  level interrupt requests
//  illegal_inst, l_access_fault, s_access_fault, ecall_m  in 1 each  sync exceptions (MEM stage)
//  mret             in   1        MRET in MEM stage
//  epc_cur          in   32       PC of the MEM-stage instruction
//  fault_addr       in   32       faulting address (load/store faults)
//  PC_redirect      out  32       redirect target
//  redirect_mux     out  1        select PC_redirect for next fetch
//  flush_all        out  1        flush IF/ID, ID/EX, EX/MEM, MEM/WB
//  RegWrite_cancel  out  1        suppress the MEM-stage register write
//  trap_busy        out  1        FSM not IDLE
// BEHAVIOUR
//  - Reset: mstatus=0 (MIE=0,MPIE=0), mie=0, mepc/mcause/mtval=0, mtvec=MTVEC_RESET, state IDLE;
//    redirect_mux, flush_all, RegWrite_cancel, trap_busy = 0.
//  - CSR map: 0x300 mstatus (bit3 MIE, bit7 MPIE, others RO 0), 0x304 mie[NUM_IRQ-1:0], 0x305 mtvec,
//    0x341 mepc (bit[1:0] RO 0), 0x342 mcause, 0x343 mtval, 0x344 mip (RO = irq_in). Other addrs read 0, writes ignored.
//  - CSR write applied at clock edge when csr_rw_in & mode!=00 & state IDLE & no trap/mret this cycle.
//  - pend = irq_in & mie[NUM_IRQ-1:0] & {NUM_IRQ{MIE}}; take_irq = |pend; winning irq = lowest index.
//  - exc = ecall_m|illegal_inst|l_access_fault|s_access_fault; exceptions always taken (MIE ignored).
//  - Priority in IDLE: exc > irq > mret. Exception order ecall(11) > illegal(2) > load fault(5) > store fault(7).
//  - FSM IDLE: trap (exc|take_irq) -> flush_all=1, RegWrite_cancel=1 combinationally same cycle; at edge:
//    mepc<=epc_cur&~3, mcause<=code (bit31 set for irq), mtval<=fault_addr for 5/7 else 0, MPIE<=MIE, MIE<=0;
//    latch target; -> REDIRECT.
//    mret (no trap) -> flush_all=1 same cycle; at edge MIE<=MPIE, MPIE<=1, target<=mepc; -> REDIRECT.
//  - FSM REDIRECT: redirect_mux=1, PC_redirect=target, trap_busy=1, flush_all=0; all inputs ignored; -> IDLE.
//  - Latency: trap detect -> redirect exactly 1 cycle; back-to-back traps separated by >=1 IDLE cycle.
//  - Interrupts are level: a request still pending when IDLE returns and MIE=1 is retaken.
//  - Trap target: {mtvec[31:2],2'b00} (direct).
//  - rst mid-REDIRECT: state->IDLE, redirect_mux=0 next cycle; captured CSRs reset.
// CONFIGURATION
//  TRAP_VECTORED_EN defined: mtvec[1:0] writable (values 00/01; 1x stored as 00); if mode=01 and trap is an
//    interrupt, target = {mtvec[31:2],2'b00} + 4*cause_code; exceptions stay direct.
//  Undefined: mtvec[1:0] hardwired 00, reads 0; all traps direct.
// TESTING
//  1 rst; write mtvec=0x100, mstatus=0x8; ecall_m @epc 0x40 -> flush same cycle, next cycle redirect to 0x100,
//    mepc=0x40, mcause=0xB, MIE=0, MPIE=1.
//  2 mie=0x0C, MIE=1, irq_in=0x0C -> mcause=0x8000_0012 (irq2, base16); irq_in=0x0C with mie=0 -> no trap.
//  3 l_access_fault & illegal_inst same cycle, fault_addr=0xDEAD_BEE0 -> mcause=2, mtval=0;
//    l_access_fault alone -> mcause=5, mtval=0xDEAD_BEE0.
//  4 trap handler: mret -> redirect to mepc next cycle, MIE restored to 1, MPIE=1; mret & ecall same cycle -> ecall wins.
//  5 CSR set/clear on mie (set 0x5, clear 0x1 -> 0x4); CSR write colliding with trap is dropped; mip write ignored.
//  6 TRAP_VECTORED_EN, mtvec=0x201, irq0 -> target 0x200+4*16=0x240; ecall -> 0x200. rst in REDIRECT -> outputs 0.

Source files
------------

// File: rtl/trap_ctrl_unit_if.sv
// CSR access bus between the pipeline (master) and the machine-mode trap controller (slave).
interface trap_ctrl_unit_if;
    logic        csr_rw_in;
    logic [1:0]  csr_wsc_mode_in;
    logic [11:0] csr_rw_addr_in;
    logic [31:0] csr_w_data;
    logic [31:0] csr_r_data_out;

    modport master (
        output csr_rw_in, csr_wsc_mode_in, csr_rw_addr_in, csr_w_data,
        input  csr_r_data_out
    );

    modport slave (
        input  csr_rw_in, csr_wsc_mode_in, csr_rw_addr_in, csr_w_data,
        output csr_r_data_out
    );
endinterface

// File: rtl/trap_ctrl_unit.sv
// Machine-mode trap controller: owns the trap CSRs, prioritises exceptions and interrupts,
// flushes the pipeline and redirects the PC. Optional vectored mtvec via TRAP_VECTORED_EN.
module trap_ctrl_unit #(
    parameter int unsigned NUM_IRQ        = 8,
    parameter int unsigned IRQ_CAUSE_BASE = 16,
    parameter logic [31:0] MTVEC_RESET    = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    trap_ctrl_unit_if.slave      csr,
    input  logic [NUM_IRQ-1:0]   irq_in,
    input  logic                 illegal_inst,
    input  logic                 l_access_fault,
    input  logic                 s_access_fault,
    input  logic                 ecall_m,
    input  logic                 mret,
    input  logic [31:0]          epc_cur,
    input  logic [31:0]          fault_addr,
    output logic [31:0]          PC_redirect,
    output logic                 redirect_mux,
    output logic                 flush_all,
    output logic                 RegWrite_cancel,
    output logic                 trap_busy
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] MTVEC_RST_VAL =
        {MTVEC_RESET[31:2], (MTVEC_RESET[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
    localparam logic [31:0] MTVEC_RST_VAL = {MTVEC_RESET[31:2], 2'b00};
`endif

    typedef enum logic {ST_IDLE, ST_REDIRECT} state_t;

    state_t               state_q, state_d;
    logic                 mie_bit_q, mie_bit_d;
    logic                 mpie_q, mpie_d;
    logic [NUM_IRQ-1:0]   mie_q, mie_d;
    logic [31:0]          mtvec_q, mtvec_d;
    logic [31:0]          mepc_q, mepc_d;
    logic [31:0]          mcause_q, mcause_d;
    logic [31:0]          mtval_q, mtval_d;
    logic [31:0]          target_q, target_d;

    logic [31:0]          rdata;
    logic [31:0]          wval;
    logic                 csr_we;
    logic [NUM_IRQ-1:0]   pend;
    logic                 take_irq;
    logic [4:0]           irq_idx;
    logic                 exc;
    logic                 exc_is_fault;
    logic [4:0]           exc_code;
    logic [30:0]          cause_code;
    logic                 trap;
    logic [31:0]          trap_base;
    logic [31:0]          trap_target;
    logic [1:0]           mtvec_mode_w;

    // CSR read port, combinational from the address
    always_comb begin
        rdata = '0;
        case (csr.csr_rw_addr_in)
            ADDR_MSTATUS: rdata = {24'h0, mpie_q, 3'b000, mie_bit_q, 3'b000};
            ADDR_MIE:     rdata = 32'(mie_q);
            ADDR_MTVEC:   rdata = mtvec_q;
            ADDR_MEPC:    rdata = mepc_q;
            ADDR_MCAUSE:  rdata = mcause_q;
            ADDR_MTVAL:   rdata = mtval_q;
            ADDR_MIP:     rdata = 32'(irq_in);
            default:      rdata = '0;
        endcase
    end
    assign csr.csr_r_data_out = rdata;

    // Trap detection and prioritisation; lowest-index interrupt wins
    always_comb begin
        pend     = irq_in & mie_q & {NUM_IRQ{mie_bit_q}};
        take_irq = |pend;
        irq_idx  = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (pend[i]) irq_idx = 5'(i);
        end
        exc          = ecall_m | illegal_inst | l_access_fault | s_access_fault;
        exc_is_fault = exc & ~ecall_m & ~illegal_inst;
        if (ecall_m)             exc_code = 5'd11;
        else if (illegal_inst)   exc_code = 5'd2;
        else if (l_access_fault) exc_code = 5'd5;
        else                     exc_code = 5'd7;
        cause_code = exc ? 31'(exc_code) : (31'(IRQ_CAUSE_BASE) + 31'(irq_idx));
        trap       = exc | take_irq;
        trap_base  = {mtvec_q[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        trap_target = (!exc && (mtvec_q[1:0] == 2'b01))
                    ? (trap_base + {cause_code[29:0], 2'b00}) : trap_base;
`else
        trap_target = trap_base;
`endif
    end

    // CSR write operand after write/set/clear
    always_comb begin
        case (csr.csr_wsc_mode_in)
            2'b10:   wval = rdata | csr.csr_w_data;
            2'b11:   wval = rdata & ~csr.csr_w_data;
            default: wval = csr.csr_w_data;
        endcase
`ifdef TRAP_VECTORED_EN
        mtvec_mode_w = (wval[1:0] == 2'b01) ? 2'b01 : 2'b00;
`else
        mtvec_mode_w = 2'b00;
`endif
        csr_we = csr.csr_rw_in & (csr.csr_wsc_mode_in != 2'b00) & (state_q == ST_IDLE)
               & ~trap & ~mret;
    end

    // Next-state: traps beat mret, which beats CSR writes
    always_comb begin
        state_d   = state_q;
        mie_bit_d = mie_bit_q;
        mpie_d    = mpie_q;
        mie_d     = mie_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        mtval_d   = mtval_q;
        target_d  = target_q;
        case (state_q)
            ST_IDLE: begin
                if (trap) begin
                    mepc_d    = {epc_cur[31:2], 2'b00};
                    mcause_d  = {~exc, cause_code};
                    mtval_d   = exc_is_fault ? fault_addr : 32'h0;
                    mpie_d    = mie_bit_q;
                    mie_bit_d = 1'b0;
                    target_d  = trap_target;
                    state_d   = ST_REDIRECT;
                end else if (mret) begin
                    mie_bit_d = mpie_q;
                    mpie_d    = 1'b1;
                    target_d  = mepc_q;
                    state_d   = ST_REDIRECT;
                end else if (csr_we) begin
                    case (csr.csr_rw_addr_in)
                        ADDR_MSTATUS: begin
                            mie_bit_d = wval[3];
                            mpie_d    = wval[7];
                        end
                        ADDR_MIE:    mie_d    = wval[NUM_IRQ-1:0];
                        ADDR_MTVEC:  mtvec_d  = {wval[31:2], mtvec_mode_w};
                        ADDR_MEPC:   mepc_d   = {wval[31:2], 2'b00};
                        ADDR_MCAUSE: mcause_d = wval;
                        ADDR_MTVAL:  mtval_d  = wval;
                        default: ;
                    endcase
                end
            end
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mie_bit_q <= 1'b0;
            mpie_q    <= 1'b0;
            mie_q     <= '0;
            mtvec_q   <= MTVEC_RST_VAL;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mtval_q   <= '0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            mie_bit_q <= mie_bit_d;
            mpie_q    <= mpie_d;
            mie_q     <= mie_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            mtval_q   <= mtval_d;
            target_q  <= target_d;
        end
    end

    // Flush and write-cancel must hit the MEM stage in the detect cycle itself
    assign flush_all       = (state_q == ST_IDLE) & (trap | mret);
    assign RegWrite_cancel = (state_q == ST_IDLE) & trap;
    assign redirect_mux    = (state_q == ST_REDIRECT);
    assign trap_busy       = (state_q == ST_REDIRECT);
    assign PC_redirect     = (state_q == ST_REDIRECT) ? target_q : 32'h0;
endmodule

// File: tb/tb_trap_ctrl_unit.sv
// Bench for trap_ctrl_unit: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against an architectural model of the trap CSRs.
module tb_trap_ctrl_unit;
    localparam int unsigned NUM_IRQ  = 8;
    localparam int unsigned IRQ_BASE = 16;
`ifdef TRAP_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [NUM_IRQ-1:0] irq_in;
    logic               illegal_inst, l_access_fault, s_access_fault, ecall_m, mret;
    logic [31:0]        epc_cur, fault_addr, PC_redirect;
    logic               redirect_mux, flush_all, RegWrite_cancel, trap_busy;

    trap_ctrl_unit_if bus ();

    trap_ctrl_unit #(.NUM_IRQ(NUM_IRQ), .IRQ_CAUSE_BASE(IRQ_BASE), .MTVEC_RESET(32'h0)) dut (
        .clk(clk), .rst(rst), .csr(bus.slave), .irq_in(irq_in),
        .illegal_inst(illegal_inst), .l_access_fault(l_access_fault),
        .s_access_fault(s_access_fault), .ecall_m(ecall_m), .mret(mret),
        .epc_cur(epc_cur), .fault_addr(fault_addr), .PC_redirect(PC_redirect),
        .redirect_mux(redirect_mux), .flush_all(flush_all),
        .RegWrite_cancel(RegWrite_cancel), .trap_busy(trap_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model state
    bit          m_valid = 1'b0;
    bit          m_busy, m_mie_b, m_mpie;
    logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_target;

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return (m_mpie ? 32'h80 : 32'h0) | (m_mie_b ? 32'h8 : 32'h0);
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return 32'(irq_in);
            default: return 32'h0;
        endcase
    endfunction

    // Which trap (if any) the architecture takes now, and its cause value
    task automatic m_decide(output bit trap, output bit is_irq, output logic [31:0] cause);
        trap = 1'b1; is_irq = 1'b0; cause = 32'h0;
        if (ecall_m)             cause = 32'd11;
        else if (illegal_inst)   cause = 32'd2;
        else if (l_access_fault) cause = 32'd5;
        else if (s_access_fault) cause = 32'd7;
        else begin
            trap = 1'b0;
            if (m_mie_b) begin
                for (int i = 0; i < int'(NUM_IRQ); i++) begin
                    if (!trap && irq_in[i] && m_mie[i]) begin
                        trap = 1'b1; is_irq = 1'b1;
                        cause = 32'h8000_0000 | (IRQ_BASE + i);
                    end
                end
            end
        end
    endtask

    // Compare on the falling edge, then advance the model to the next rising edge
    initial begin
        bit t, irq;
        logic [31:0] cause, oldv, nv;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_valid = 1'b1; m_busy = 0; m_mie_b = 0; m_mpie = 0;
                m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_target = 0;
            end else if (m_valid) begin
                m_decide(t, irq, cause);
                chk("trap_busy", 32'(trap_busy), 32'(m_busy));
                chk("redirect_mux", 32'(redirect_mux), 32'(m_busy));
                if (m_busy) chk("pc_redirect", PC_redirect, m_target);
                chk("flush_all", 32'(flush_all), 32'(!m_busy && (t || mret)));
                chk("regwrite_cancel", 32'(RegWrite_cancel), 32'(!m_busy && t));
                chk("csr_rdata", bus.csr_r_data_out, m_read(bus.csr_rw_addr_in));
                if (m_busy) begin
                    m_busy = 0;
                end else if (t) begin
                    m_mepc = epc_cur & ~32'h3;
                    m_mcause = cause;
                    m_mtval = (cause == 32'd5 || cause == 32'd7) ? fault_addr : 32'h0;
                    m_mpie = m_mie_b; m_mie_b = 0;
                    m_target = m_mtvec & ~32'h3;
                    if (VEC && irq && m_mtvec[1:0] == 2'b01)
                        m_target = m_target + 4 * (cause & 32'h7FFF_FFFF);
                    m_busy = 1;
                end else if (mret) begin
                    m_mie_b = m_mpie; m_mpie = 1; m_target = m_mepc; m_busy = 1;
                end else if (bus.csr_rw_in && bus.csr_wsc_mode_in != 2'b00) begin
                    oldv = m_read(bus.csr_rw_addr_in);
                    case (bus.csr_wsc_mode_in)
                        2'b01:   nv = bus.csr_w_data;
                        2'b10:   nv = oldv | bus.csr_w_data;
                        default: nv = oldv & ~bus.csr_w_data;
                    endcase
                    case (bus.csr_rw_addr_in)
                        12'h300: begin m_mie_b = nv[3]; m_mpie = nv[7]; end
                        12'h304: m_mie = nv & ((32'h1 << NUM_IRQ) - 1);
                        12'h305: m_mtvec = (nv & ~32'h3) | ((VEC && nv[1:0] == 2'b01) ? 32'h1 : 32'h0);
                        12'h341: m_mepc = nv & ~32'h3;
                        12'h342: m_mcause = nv;
                        12'h343: m_mtval = nv;
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic clear_inputs();
        rst = 0; irq_in = '0; illegal_inst = 0; l_access_fault = 0; s_access_fault = 0;
        ecall_m = 0; mret = 0; epc_cur = 0; fault_addr = 0;
        bus.csr_rw_in = 0; bus.csr_wsc_mode_in = 2'b00; bus.csr_rw_addr_in = 12'h0;
        bus.csr_w_data = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic csr_op(input logic [1:0] mode, input logic [11:0] a, input logic [31:0] d);
        step();
        bus.csr_rw_in = 1; bus.csr_wsc_mode_in = mode; bus.csr_rw_addr_in = a; bus.csr_w_data = d;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        step();
        bus.csr_rw_addr_in = a;
        #2 chk(name, bus.csr_r_data_out, exp);
    endtask

    logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};

    initial begin
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state
        #2 chk("rst_redirect_mux", 32'(redirect_mux), 32'h0);
        chk("rst_busy", 32'(trap_busy), 32'h0);
        rd_chk("rst_mstatus", 12'h300, 32'h0);

        // ecall, direct vector
        csr_op(2'b01, 12'h305, 32'h100);
        csr_op(2'b01, 12'h300, 32'h8);
        step(); ecall_m = 1; epc_cur = 32'h40;
        #2 chk("t1_flush", 32'(flush_all), 32'h1);
        chk("t1_cancel", 32'(RegWrite_cancel), 32'h1);
        chk("t1_no_redirect_yet", 32'(redirect_mux), 32'h0);
        step();
        #2 chk("t1_redirect", 32'(redirect_mux), 32'h1);
        chk("t1_pc", PC_redirect, 32'h100);
        chk("t1_flush_off", 32'(flush_all), 32'h0);
        rd_chk("t1_mepc", 12'h341, 32'h40);
        rd_chk("t1_mcause", 12'h342, 32'hB);
        rd_chk("t1_mstatus", 12'h300, 32'h80);

        // mret back to mepc
        step(); mret = 1;
        #2 chk("t4_mret_flush", 32'(flush_all), 32'h1);
        chk("t4_mret_nocancel", 32'(RegWrite_cancel), 32'h0);
        step();
        #2 chk("t4_mret_pc", PC_redirect, 32'h40);
        rd_chk("t4_mstatus", 12'h300, 32'h88);

        // Interrupt: irq2 wins over irq3
        csr_op(2'b01, 12'h304, 32'h0C);
        step(); irq_in = 8'h0C;
        #2 chk("t2_irq_cancel", 32'(RegWrite_cancel), 32'h1);
        step();
        rd_chk("t2_mcause", 12'h342, 32'h8000_0012);
        step(); mret = 1;
        step();
        csr_op(2'b11, 12'h304, 32'hFFFF_FFFF);
        step(); irq_in = 8'h0C;
        #2 chk("t2_masked_no_flush", 32'(flush_all), 32'h0);
        step();
        #2 chk("t2_masked_idle", 32'(trap_busy), 32'h0);

        // Exception priority and mtval
        step(); l_access_fault = 1; illegal_inst = 1; fault_addr = 32'hDEAD_BEE0; epc_cur = 32'h80;
        step();
        rd_chk("t3_mcause_illegal", 12'h342, 32'h2);
        rd_chk("t3_mtval_zero", 12'h343, 32'h0);
        step(); l_access_fault = 1; fault_addr = 32'hDEAD_BEE0;
        step();
        rd_chk("t3_mcause_load", 12'h342, 32'h5);
        rd_chk("t3_mtval_addr", 12'h343, 32'hDEAD_BEE0);

        // mret and ecall together: ecall wins
        step(); mret = 1; ecall_m = 1; epc_cur = 32'h44;
        step();
        rd_chk("t4_ecall_wins", 12'h342, 32'hB);
        rd_chk("t4_mepc", 12'h341, 32'h44);

        // CSR set/clear, collision, read-only mip, unmapped address
        csr_op(2'b01, 12'h304, 32'h0);
        csr_op(2'b10, 12'h304, 32'h5);
        csr_op(2'b11, 12'h304, 32'h1);
        rd_chk("t5_mie_setclr", 12'h304, 32'h4);
        csr_op(2'b01, 12'h304, 32'hFF); ecall_m = 1;
        step();
        rd_chk("t5_collision_dropped", 12'h304, 32'h4);
        csr_op(2'b01, 12'h344, 32'hFF);
        rd_chk("t5_mip_ro", 12'h344, 32'h0);
        step(); irq_in = 8'h81; bus.csr_rw_addr_in = 12'h344;
        #2 chk("t5_mip_level", bus.csr_r_data_out, 32'h81);
        csr_op(2'b01, 12'h7C0, 32'h1234);
        rd_chk("t5_unmapped", 12'h7C0, 32'h0);

        // Vectored mode (direct when the feature is built out)
        csr_op(2'b01, 12'h305, 32'h201);
        rd_chk("t6_mtvec", 12'h305, VEC ? 32'h201 : 32'h200);
        csr_op(2'b01, 12'h304, 32'h1);
        csr_op(2'b10, 12'h300, 32'h8);
        step(); irq_in = 8'h01;
        step();
        #2 chk("t6_irq_target", PC_redirect, VEC ? 32'h240 : 32'h200);
        step(); mret = 1;
        step();
        step(); ecall_m = 1; epc_cur = 32'h43;
        step();
        #2 chk("t6_exc_direct", PC_redirect, 32'h200);
        rd_chk("t6_mepc_aligned", 12'h341, 32'h40);

        // Reset while redirecting
        step(); ecall_m = 1;
        step();
        #2 chk("t6_pre_rst_redirect", 32'(redirect_mux), 32'h1);
        rst = 1;
        step(); bus.csr_rw_addr_in = 12'h341;
        #2 chk("t6_rst_redirect", 32'(redirect_mux), 32'h0);
        chk("t6_rst_busy", 32'(trap_busy), 32'h0);
        chk("t6_rst_mepc", bus.csr_r_data_out, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step();
            if ($urandom_range(0, 199) == 0) rst = 1;
            if ($urandom_range(0, 4) == 0) irq_in = NUM_IRQ'($urandom);
            illegal_inst   = ($urandom_range(0, 19) == 0);
            l_access_fault = ($urandom_range(0, 19) == 0);
            s_access_fault = ($urandom_range(0, 19) == 0);
            ecall_m        = ($urandom_range(0, 19) == 0);
            mret           = ($urandom_range(0, 11) == 0);
            epc_cur        = $urandom;
            fault_addr     = $urandom;
            bus.csr_rw_in       = ($urandom_range(0, 1) == 1);
            bus.csr_wsc_mode_in = 2'($urandom);
            bus.csr_rw_addr_in  = addrs[$urandom_range(0, 7)];
            bus.csr_w_data      = ($urandom_range(0, 2) == 0) ? 32'h88 : $urandom;
        end
        step();
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
